// File: rtl/tl_arb_pkg.sv
// Shared definitions for the two-client TileLink-UL fragmenter arbiter:
// opcodes, arbiter FSM states and the Put burst-length decode.
package tl_arb_pkg;

  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] GET         = 3'd4;
  localparam logic [2:0] ACK         = 3'd0;
  localparam logic [2:0] ACK_DATA    = 3'd1;

  typedef enum logic {StIdle, StBusy} arb_state_e;

  // Number of A beats in a request; only Puts wider than one 8-byte beat are multi-beat.
  function automatic logic [4:0] beats(input logic [2:0] op, input logic [2:0] size);
    logic [4:0] n;
    n = 5'd1;
    if ((op == PUT_FULL || op == PUT_PARTIAL) && size > 3'd3) begin
      n = 5'd1 << (size - 3'd3);
    end
    return n;
  endfunction

endpackage

// File: rtl/tl_rr_picker.sv
// Two-way round-robin picker: a lone requester wins, a tie (or no request) goes to rr_i.
module tl_rr_picker (
  input  logic [1:0] req_i,
  input  logic       rr_i,
  output logic       sel_o
);

  always_comb begin
    sel_o = rr_i;
    case (req_i)
      2'b01:   sel_o = 1'b0;
      2'b10:   sel_o = 1'b1;
      default: sel_o = rr_i;
    endcase
  end

endmodule

// File: rtl/tl_fragmenter_arbiter.sv
// Shares one TLFragmenter A/D port between two TileLink-UL clients. The A channel is granted
// round-robin and held for whole Put bursts; D beats are routed back by the source tag bit.
module tl_fragmenter_arbiter
  import tl_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned SRC_W  = 2
) (
  input  logic                clock,
  input  logic                reset,

  input  logic                in0_a_valid,
  output logic                in0_a_ready,
  input  logic [2:0]          in0_a_bits_opcode,
  input  logic [2:0]          in0_a_bits_param,
  input  logic [2:0]          in0_a_bits_size,
  input  logic [SRC_W-1:0]    in0_a_bits_source,
  input  logic [ADDR_W-1:0]   in0_a_bits_address,
  input  logic [DATA_W/8-1:0] in0_a_bits_mask,
  input  logic [DATA_W-1:0]   in0_a_bits_data,
  input  logic                in0_a_bits_corrupt,
  input  logic                in0_d_ready,
  output logic                in0_d_valid,
  output logic [2:0]          in0_d_bits_opcode,
  output logic [2:0]          in0_d_bits_size,
  output logic [SRC_W-1:0]    in0_d_bits_source,
  output logic [DATA_W-1:0]   in0_d_bits_data,

  input  logic                in1_a_valid,
  output logic                in1_a_ready,
  input  logic [2:0]          in1_a_bits_opcode,
  input  logic [2:0]          in1_a_bits_param,
  input  logic [2:0]          in1_a_bits_size,
  input  logic [SRC_W-1:0]    in1_a_bits_source,
  input  logic [ADDR_W-1:0]   in1_a_bits_address,
  input  logic [DATA_W/8-1:0] in1_a_bits_mask,
  input  logic [DATA_W-1:0]   in1_a_bits_data,
  input  logic                in1_a_bits_corrupt,
  input  logic                in1_d_ready,
  output logic                in1_d_valid,
  output logic [2:0]          in1_d_bits_opcode,
  output logic [2:0]          in1_d_bits_size,
  output logic [SRC_W-1:0]    in1_d_bits_source,
  output logic [DATA_W-1:0]   in1_d_bits_data,

  output logic                out_a_valid,
  input  logic                out_a_ready,
  output logic [2:0]          out_a_bits_opcode,
  output logic [2:0]          out_a_bits_param,
  output logic [2:0]          out_a_bits_size,
  output logic [SRC_W:0]      out_a_bits_source,
  output logic [ADDR_W-1:0]   out_a_bits_address,
  output logic [DATA_W/8-1:0] out_a_bits_mask,
  output logic [DATA_W-1:0]   out_a_bits_data,
  output logic                out_a_bits_corrupt,
  output logic                out_d_ready,
  input  logic                out_d_valid,
  input  logic [2:0]          out_d_bits_opcode,
  input  logic [2:0]          out_d_bits_size,
  input  logic [SRC_W:0]      out_d_bits_source,
  input  logic [DATA_W-1:0]   out_d_bits_data
);

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       rr_q, rr_d;
  logic [4:0] rem_q, rem_d;

  logic       pick_sel;
  logic       sel;
  logic [2:0] sel_op;
  logic [2:0] sel_size;
  logic [4:0] sel_beats;
  logic       fire;
  logic       d_tag;

  tl_rr_picker u_picker (
    .req_i ({in1_a_valid, in0_a_valid}),
    .rr_i  (rr_q),
    .sel_o (pick_sel)
  );

  assign sel       = (state_q == StBusy) ? grant_q : pick_sel;
  assign sel_op    = sel ? in1_a_bits_opcode : in0_a_bits_opcode;
  assign sel_size  = sel ? in1_a_bits_size : in0_a_bits_size;
  assign sel_beats = beats(sel_op, sel_size);
  assign fire      = out_a_valid & out_a_ready;
  assign d_tag     = out_d_bits_source[SRC_W];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      rr_q    <= 1'b0;
      rem_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    rem_d   = rem_q;
    unique case (state_q)
      StIdle: begin
        // A stalled head request is locked in BUSY so its fields cannot change under valid.
        if (out_a_valid) begin
          if (!out_a_ready) begin
            state_d = StBusy;
            grant_d = sel;
            rem_d   = sel_beats;
          end else if (sel_beats == 5'd1) begin
            rr_d = ~sel;
          end else begin
            state_d = StBusy;
            grant_d = sel;
            rem_d   = sel_beats - 5'd1;
          end
        end
      end
      StBusy: begin
        if (fire) begin
          rem_d = rem_q - 5'd1;
          if (rem_q == 5'd1) begin
            state_d = StIdle;
            rr_d    = ~grant_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_a_valid        = ~reset & (sel ? in1_a_valid : in0_a_valid);
    out_a_bits_opcode  = sel_op;
    out_a_bits_param   = sel ? in1_a_bits_param : in0_a_bits_param;
    out_a_bits_size    = sel_size;
    out_a_bits_source  = {sel, (sel ? in1_a_bits_source : in0_a_bits_source)};
    out_a_bits_address = sel ? in1_a_bits_address : in0_a_bits_address;
    out_a_bits_mask    = sel ? in1_a_bits_mask : in0_a_bits_mask;
    out_a_bits_data    = sel ? in1_a_bits_data : in0_a_bits_data;
    out_a_bits_corrupt = sel ? in1_a_bits_corrupt : in0_a_bits_corrupt;
    in0_a_ready        = ~reset & ~sel & out_a_ready;
    in1_a_ready        = ~reset & sel & out_a_ready;

    in0_d_valid        = ~reset & ~d_tag & out_d_valid;
    in1_d_valid        = ~reset & d_tag & out_d_valid;
    out_d_ready        = ~reset & (d_tag ? in1_d_ready : in0_d_ready);
    in0_d_bits_opcode  = out_d_bits_opcode;
    in0_d_bits_size    = out_d_bits_size;
    in0_d_bits_source  = out_d_bits_source[SRC_W-1:0];
    in0_d_bits_data    = out_d_bits_data;
    in1_d_bits_opcode  = out_d_bits_opcode;
    in1_d_bits_size    = out_d_bits_size;
    in1_d_bits_source  = out_d_bits_source[SRC_W-1:0];
    in1_d_bits_data    = out_d_bits_data;
  end

endmodule

// File: tb/tb_tl_fragmenter_arbiter.sv
// Directed and randomised checks of A-channel arbitration and D-channel routing.
module tb_tl_fragmenter_arbiter;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned SRC_W  = 2;

  logic        clock = 1'b0;
  logic        reset;

  logic [1:0]  a_valid;
  logic [1:0]  a_ready;
  logic [2:0]  a_op    [2];
  logic [2:0]  a_param [2];
  logic [2:0]  a_size  [2];
  logic [1:0]  a_src   [2];
  logic [11:0] a_addr  [2];
  logic [7:0]  a_mask  [2];
  logic [63:0] a_data  [2];
  logic [1:0]  a_corrupt;
  logic [1:0]  d_ready;
  logic [1:0]  d_valid;
  logic [2:0]  d_op    [2];
  logic [2:0]  d_size  [2];
  logic [1:0]  d_src   [2];
  logic [63:0] d_data  [2];

  logic        o_a_valid, o_a_ready, o_a_corrupt;
  logic [2:0]  o_a_op, o_a_param, o_a_size, o_a_src;
  logic [11:0] o_a_addr;
  logic [7:0]  o_a_mask;
  logic [63:0] o_a_data;
  logic        o_d_valid, o_d_ready;
  logic [2:0]  o_d_op, o_d_size, o_d_src;
  logic [63:0] o_d_data;

  int total = 0;
  int bad   = 0;

  int          c_rem [2];
  logic [1:0]  fired;
  logic        owner, p_stall, p_tag, tag, dt;
  logic [4:0]  owner_rem, nb;
  logic [11:0] p_addr;
  logic [2:0]  r_op;

  always #5 clock = ~clock;

  tl_fragmenter_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W)) dut (
    .clock              (clock),
    .reset              (reset),
    .in0_a_valid        (a_valid[0]),
    .in0_a_ready        (a_ready[0]),
    .in0_a_bits_opcode  (a_op[0]),
    .in0_a_bits_param   (a_param[0]),
    .in0_a_bits_size    (a_size[0]),
    .in0_a_bits_source  (a_src[0]),
    .in0_a_bits_address (a_addr[0]),
    .in0_a_bits_mask    (a_mask[0]),
    .in0_a_bits_data    (a_data[0]),
    .in0_a_bits_corrupt (a_corrupt[0]),
    .in0_d_ready        (d_ready[0]),
    .in0_d_valid        (d_valid[0]),
    .in0_d_bits_opcode  (d_op[0]),
    .in0_d_bits_size    (d_size[0]),
    .in0_d_bits_source  (d_src[0]),
    .in0_d_bits_data    (d_data[0]),
    .in1_a_valid        (a_valid[1]),
    .in1_a_ready        (a_ready[1]),
    .in1_a_bits_opcode  (a_op[1]),
    .in1_a_bits_param   (a_param[1]),
    .in1_a_bits_size    (a_size[1]),
    .in1_a_bits_source  (a_src[1]),
    .in1_a_bits_address (a_addr[1]),
    .in1_a_bits_mask    (a_mask[1]),
    .in1_a_bits_data    (a_data[1]),
    .in1_a_bits_corrupt (a_corrupt[1]),
    .in1_d_ready        (d_ready[1]),
    .in1_d_valid        (d_valid[1]),
    .in1_d_bits_opcode  (d_op[1]),
    .in1_d_bits_size    (d_size[1]),
    .in1_d_bits_source  (d_src[1]),
    .in1_d_bits_data    (d_data[1]),
    .out_a_valid        (o_a_valid),
    .out_a_ready        (o_a_ready),
    .out_a_bits_opcode  (o_a_op),
    .out_a_bits_param   (o_a_param),
    .out_a_bits_size    (o_a_size),
    .out_a_bits_source  (o_a_src),
    .out_a_bits_address (o_a_addr),
    .out_a_bits_mask    (o_a_mask),
    .out_a_bits_data    (o_a_data),
    .out_a_bits_corrupt (o_a_corrupt),
    .out_d_ready        (o_d_ready),
    .out_d_valid        (o_d_valid),
    .out_d_bits_opcode  (o_d_op),
    .out_d_bits_size    (o_d_size),
    .out_d_bits_source  (o_d_src),
    .out_d_bits_data    (o_d_data)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_a(input int i, input logic v, input logic [2:0] op, input logic [2:0] sz,
                       input logic [1:0] src, input logic [11:0] addr, input logic [63:0] data);
    a_valid[i]   = v;
    a_op[i]      = op;
    a_param[i]   = 3'd0;
    a_size[i]    = sz;
    a_src[i]     = src;
    a_addr[i]    = addr;
    a_mask[i]    = 8'hff;
    a_data[i]    = data;
    a_corrupt[i] = 1'b0;
  endtask

  function automatic logic [4:0] tb_beats(input logic [2:0] op, input logic [2:0] sz);
    if (op > 3'd1) return 5'd1;
    case (sz)
      3'd4:    return 5'd2;
      3'd5:    return 5'd4;
      3'd6:    return 5'd8;
      3'd7:    return 5'd16;
      default: return 5'd1;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    set_a(0, 1'b1, 3'd4, 3'd3, 2'd0, 12'h010, 64'h10);
    set_a(1, 1'b1, 3'd4, 3'd3, 2'd0, 12'h020, 64'h20);
    o_a_ready = 1'b1;
    o_d_valid = 1'b1;
    o_d_src   = 3'b100;
    o_d_op    = 3'd0;
    o_d_size  = 3'd3;
    o_d_data  = 64'h0;
    d_ready   = 2'b11;
    #1;
    chk("rst_out_a_valid", o_a_valid, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_out_d_ready", o_d_ready, 0);
    tick();
    tick();
    reset     = 1'b0;
    a_valid   = 2'b00;
    o_a_ready = 1'b0;
    o_d_valid = 1'b0;
    d_ready   = 2'b00;
    #1;
    chk("idle_out_a_valid", o_a_valid, 0);
    chk("idle_a_ready", a_ready, 0);
    chk("idle_d_valid", d_valid, 0);
    chk("idle_out_d_ready", o_d_ready, 0);
    tick();

    // Simultaneous Gets: in0 first (rr=0), then in1.
    set_a(0, 1'b1, 3'd4, 3'd3, 2'b11, 12'h100, 64'h1111);
    set_a(1, 1'b1, 3'd4, 3'd3, 2'b10, 12'h200, 64'h2222);
    o_a_ready = 1'b1;
    #1;
    chk("t1_src0", o_a_src, 3'b011);
    chk("t1_addr0", o_a_addr, 12'h100);
    chk("t1_rdy0", a_ready, 2'b01);
    tick();
    a_valid[0] = 1'b0;
    #1;
    chk("t1_src1", o_a_src, 3'b110);
    chk("t1_addr1", o_a_addr, 12'h200);
    chk("t1_rdy1", a_ready, 2'b10);
    tick();
    a_valid[1] = 1'b0;
    #1;
    chk("t1_idle", o_a_valid, 0);

    // 4-beat PutFull from in0 while in1 waits.
    set_a(0, 1'b1, 3'd0, 3'd5, 2'b01, 12'h040, 64'hA0);
    set_a(1, 1'b1, 3'd4, 3'd3, 2'b00, 12'h300, 64'hB0);
    for (int b = 0; b < 4; b++) begin
      a_data[0] = 64'hA0 + 64'(b);
      #1;
      chk("t2_tag", o_a_src, 3'b001);
      chk("t2_data", o_a_data, 64'hA0 + 64'(b));
      chk("t2_rdy", a_ready, 2'b01);
      tick();
    end
    set_a(0, 1'b1, 3'd4, 3'd3, 2'b01, 12'h050, 64'hC0);
    #1;
    chk("t2_handoff_src", o_a_src, 3'b100);
    chk("t2_handoff_rdy", a_ready, 2'b10);
    tick();
    a_valid[1] = 1'b0;
    #1;
    chk("t2_in0_after", o_a_src, 3'b001);
    tick();
    a_valid[0] = 1'b0;

    // Stall with in0 pending; in1 arrives while in0 is locked.
    o_a_ready = 1'b0;
    set_a(0, 1'b1, 3'd4, 3'd3, 2'b10, 12'h3a0, 64'hD0);
    #1;
    chk("t3_c0_src", o_a_src, 3'b010);
    chk("t3_c0_rdy", a_ready, 2'b00);
    tick();
    set_a(1, 1'b1, 3'd4, 3'd3, 2'b11, 12'h3b0, 64'hE0);
    #1;
    chk("t3_c1_src", o_a_src, 3'b010);
    chk("t3_c1_addr", o_a_addr, 12'h3a0);
    chk("t3_c1_rdy", a_ready, 2'b00);
    tick();
    #1;
    chk("t3_c2_src", o_a_src, 3'b010);
    tick();
    o_a_ready = 1'b1;
    #1;
    chk("t3_fire_rdy", a_ready, 2'b01);
    chk("t3_fire_addr", o_a_addr, 12'h3a0);
    tick();
    a_valid[0] = 1'b0;
    #1;
    chk("t3_in1_src", o_a_src, 3'b111);
    tick();
    a_valid[1] = 1'b0;

    // D routing by tag bit.
    o_d_valid = 1'b1;
    o_d_src   = 3'b101;
    o_d_op    = 3'd1;
    o_d_size  = 3'd3;
    o_d_data  = 64'h0123_4567_89ab_cdef;
    d_ready   = 2'b01;
    #1;
    chk("t4_d_valid", d_valid, 2'b10);
    chk("t4_d_src1", d_src[1], 2'b01);
    chk("t4_d_op1", d_op[1], 3'd1);
    chk("t4_d_size1", d_size[1], 3'd3);
    chk("t4_d_data1", d_data[1], 64'h0123_4567_89ab_cdef);
    chk("t4_out_d_ready_lo", o_d_ready, 0);
    tick();
    d_ready = 2'b11;
    #1;
    chk("t4_out_d_ready_hi", o_d_ready, 1);
    tick();
    o_d_src = 3'b010;
    o_d_op  = 3'd0;
    d_ready = 2'b01;
    #1;
    chk("t4_d_valid0", d_valid, 2'b01);
    chk("t4_d_src0", d_src[0], 2'b10);
    chk("t4_out_d_ready0", o_d_ready, 1);
    tick();
    o_d_valid = 1'b0;
    d_ready   = 2'b00;

    // Reset mid-way through an 8-beat Put.
    set_a(0, 1'b1, 3'd4, 3'd3, 2'b00, 12'h070, 64'h70);
    tick();
    set_a(0, 1'b1, 3'd1, 3'd6, 2'b00, 12'h080, 64'hF0);
    #1;
    chk("t5_b0_src", o_a_src, 3'b000);
    chk("t5_b0_rdy", a_ready, 2'b01);
    tick();
    a_data[0] = 64'hF1;
    #1;
    chk("t5_b1_rdy", a_ready, 2'b01);
    tick();
    reset = 1'b1;
    set_a(1, 1'b1, 3'd4, 3'd3, 2'b10, 12'h0d0, 64'h1D);
    o_d_valid = 1'b1;
    o_d_src   = 3'b100;
    d_ready   = 2'b11;
    #1;
    chk("t5_rst_out_a_valid", o_a_valid, 0);
    chk("t5_rst_a_ready", a_ready, 0);
    chk("t5_rst_d_valid", d_valid, 0);
    chk("t5_rst_out_d_ready", o_d_ready, 0);
    tick();
    reset     = 1'b0;
    o_d_valid = 1'b0;
    d_ready   = 2'b00;
    set_a(0, 1'b1, 3'd4, 3'd3, 2'b01, 12'h0c0, 64'h1C);
    #1;
    chk("t5_post_tie_src", o_a_src, 3'b001);
    chk("t5_post_tie_rdy", a_ready, 2'b01);
    tick();
    a_valid[0] = 1'b0;
    #1;
    chk("t5_post_in1_src", o_a_src, 3'b110);
    chk("t5_post_in1_rdy", a_ready, 2'b10);
    tick();
    a_valid[1] = 1'b0;

    // Randomised concurrent A/D traffic against a burst-ownership model.
    c_rem[0]  = 0;
    c_rem[1]  = 0;
    fired     = 2'b00;
    owner     = 1'b0;
    owner_rem = 5'd0;
    p_stall   = 1'b0;
    p_tag     = 1'b0;
    p_addr    = 12'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (fired[i]) begin
          c_rem[i]--;
          a_data[i] = {$urandom, $urandom};
          if (c_rem[i] == 0) a_valid[i] = 1'b0;
        end
        if (!a_valid[i] && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 2))
            0:       r_op = 3'd0;
            1:       r_op = 3'd1;
            default: r_op = 3'd4;
          endcase
          set_a(i, 1'b1, r_op, 3'($urandom_range(3, 7)), 2'($urandom), 12'($urandom),
                {$urandom, $urandom});
          a_mask[i]  = 8'($urandom);
          a_param[i] = 3'($urandom);
          c_rem[i]   = int'(tb_beats(a_op[i], a_size[i]));
        end
      end
      o_a_ready = ($urandom_range(0, 3) != 0);
      o_d_valid = 1'($urandom);
      o_d_src   = 3'($urandom);
      o_d_op    = 3'($urandom);
      o_d_size  = 3'($urandom);
      o_d_data  = {$urandom, $urandom};
      d_ready   = 2'($urandom);
      #1;
      tag = o_a_src[2];
      chk("r_a_valid", o_a_valid, a_valid[tag]);
      chk("r_a_addr", o_a_addr, a_addr[tag]);
      chk("r_a_data", o_a_data, a_data[tag]);
      chk("r_a_fields", {o_a_op, o_a_size, o_a_param, o_a_corrupt, o_a_mask, o_a_src[1:0]},
          {a_op[tag], a_size[tag], a_param[tag], a_corrupt[tag], a_mask[tag], a_src[tag]});
      chk("r_a_ready", a_ready, o_a_ready ? (2'b01 << tag) : 2'b00);
      if (p_stall) chk("r_a_hold", {o_a_valid, tag, o_a_addr}, {1'b1, p_tag, p_addr});
      if (owner_rem != 5'd0) chk("r_a_burst_owner", tag, owner);
      if (o_a_valid && o_a_ready) begin
        if (owner_rem != 5'd0) begin
          owner_rem = owner_rem - 5'd1;
        end else begin
          nb = tb_beats(o_a_op, o_a_size);
          if (nb > 5'd1) begin
            owner     = tag;
            owner_rem = nb - 5'd1;
          end
        end
      end
      p_stall = o_a_valid & ~o_a_ready;
      p_tag   = tag;
      p_addr  = o_a_addr;
      fired   = a_valid & a_ready;
      dt = o_d_src[2];
      chk("r_d_valid", d_valid, o_d_valid ? (2'b01 << dt) : 2'b00);
      chk("r_d_ready", o_d_ready, d_ready[dt]);
      chk("r_d_src", d_src[dt], o_d_src[1:0]);
      chk("r_d_bits", {d_op[dt], d_size[dt], d_data[dt][57:0]},
          {o_d_op, o_d_size, o_d_data[57:0]});
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
